// File: rtl/note_detector.sv
// Square-wave half-period meter; `define NOTE_DETECTOR_MATCH_EN to accept only measurements within 1 of the previous one.
// Latency: valid 3 clk after the first clk edge sampling a new sig_in level; no backpressure, valid is a one-cycle pulse.
module note_detector #(
  parameter int FREQ_W   = 13,
  parameter int MIN_HALF = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sig_in,
  output logic [FREQ_W-1:0] freq,
  output logic              ring,
  output logic              valid
);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

  localparam logic [FREQ_W-1:0] CNT_MAX = {FREQ_W{1'b1}};
  localparam logic [FREQ_W-1:0] CNT_ONE = FREQ_W'(1);
  localparam logic [FREQ_W-1:0] MIN_CNT = FREQ_W'(MIN_HALF);

  state_t            state;
  logic              sync1, sync2, sync3, edge_p;
  logic [FREQ_W-1:0] cnt;
  logic              hit;
  logic              accept;

  // Edges closer than MIN_HALF to the last accepted edge are glitches; the count keeps running through them.
  assign hit = edge_p && (cnt >= MIN_CNT);

`ifdef NOTE_DETECTOR_MATCH_EN
  logic [FREQ_W-1:0] prev;
  logic [FREQ_W-1:0] diff;
  logic              prev_ok;

  assign diff   = (cnt >= prev) ? (cnt - prev) : (prev - cnt);
  assign accept = prev_ok && (diff <= CNT_ONE);

  // The arming edge from IDLE has no real interval behind it, so it never serves as a partner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= '0;
      prev_ok <= 1'b0;
    end else if (hit) begin
      prev    <= cnt;
      prev_ok <= (state != IDLE);
    end
  end
`else
  assign accept = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      edge_p <= 1'b0;
      cnt    <= '0;
      state  <= IDLE;
      freq   <= '0;
      ring   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      sync1  <= sig_in;
      sync2  <= sync1;
      sync3  <= sync2;
      edge_p <= sync2 ^ sync3;
      valid  <= 1'b0;

      if (hit) begin
        cnt <= CNT_ONE;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end

      case (state)
        IDLE: begin
          if (hit) begin
            state <= ARMED;
          end
        end
        ARMED, LOCKED: begin
          if (hit) begin
            if (accept) begin
              freq  <= cnt;
              ring  <= 1'b1;
              valid <= 1'b1;
              state <= LOCKED;
            end
          end else if (cnt == CNT_MAX) begin
            // Tone lost: freq keeps the last accepted value.
            state <= IDLE;
            ring  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_detector.sv
// Randomized and directed bench for note_detector against a time-based model of the half-period rules.
module tb_note_detector;

  localparam int FW    = 13;
  localparam int MAXC  = (1 << FW) - 1;
  localparam int MIN_H = 3;
`ifdef NOTE_DETECTOR_MATCH_EN
  localparam bit MATCH = 1'b1;
`else
  localparam bit MATCH = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sig_in = 1'b0;
  logic [FW-1:0] freq;
  logic          ring;
  logic          valid;

  int checks   = 0;
  int failures = 0;
  logic cur    = 1'b0;

  // Model: edges seen by the detector 3 clk after sampling, timing measured from the last accepted edge.
  logic          q[$];
  int            c, anchor, prev;
  bit            active, have_prev;
  logic [FW-1:0] m_freq;
  logic          m_ring, m_valid;

  note_detector #(.FREQ_W(FW), .MIN_HALF(MIN_H)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .freq   (freq),
    .ring   (ring),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q = '{1'b0, 1'b0, 1'b0, 1'b0};
    c = 0; anchor = 0; prev = 0;
    active = 1'b0; have_prev = 1'b0;
    m_freq = '0; m_ring = 1'b0; m_valid = 1'b0;
  endtask

  task automatic model_tick(input logic s);
    int m, d;
    logic e;
    q.push_back(s);
    e = q[q.size()-4] ^ q[q.size()-5];
    if (q.size() > 8) void'(q.pop_front());
    m = c - anchor;
    if (m > MAXC) m = MAXC;
    m_valid = 1'b0;
    if (e && m >= MIN_H) begin
      if (active) begin
        d = (m > prev) ? m - prev : prev - m;
        if (!MATCH || (have_prev && d <= 1)) begin
          m_freq = m[FW-1:0]; m_ring = 1'b1; m_valid = 1'b1;
        end
        have_prev = 1'b1;
      end else begin
        active = 1'b1; have_prev = 1'b0;
      end
      prev = m; anchor = c;
    end else if (active && m == MAXC) begin
      active = 1'b0; m_ring = 1'b0;
    end
    c++;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic s);
    sig_in = s; cur = s;
    @(posedge clk);
    model_tick(s);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic s);
    rst_n = 1'b0; sig_in = s; cur = s;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wave(input int n, input int k);
    for (int j = 0; j < k; j++) begin
      step(~cur);
      repeat (n - 1) step(cur);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; sig_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (freq !== '0) begin failures++; $display("FAIL reset_freq got=%0d exp=0", freq); end
    checks++; if (ring !== 1'b0) begin failures++; $display("FAIL reset_ring got=%b exp=0", ring); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    repeat (3) @(negedge clk);
    checks++;
    if ({valid, ring, freq} !== {2'b00, {FW{1'b0}}}) begin
      failures++; $display("FAIL reset_hold got v=%b r=%b f=%0d exp all 0", valid, ring, freq);
    end
  endtask

  // sig_in held high through reset release; that transition only arms.
  task automatic test_tone();
    int fe;
    fe = MATCH ? 23 : 13;
    do_reset(1'b1);
    for (int i = 0; i < 63; i++) begin
      step(((i / 10) % 2 == 0) ? 1'b1 : 1'b0);
      checks++;
      if ({valid, ring, freq} !== {(i >= fe) && ((i - fe) % 10 == 0), i >= fe, (i >= fe) ? FW'(10) : FW'(0)}) begin
        failures++; $display("FAIL tone_lit i=%0d got v=%b r=%b f=%0d first_valid=%0d", i, valid, ring, freq, fe);
      end
      checks++;
      if ({valid, ring, freq} !== {m_valid, m_ring, m_freq}) begin
        failures++; $display("FAIL tone_model i=%0d got v=%b r=%b f=%0d exp v=%b r=%b f=%0d", i, valid, ring, freq, m_valid, m_ring, m_freq);
      end
    end
  endtask

  task automatic test_glitch();
    int nv;
    nv = 0;
    do_reset(1'b0);
    wave(10, 4);
    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 0) step(~cur);
      else if (i == 1) step(~cur);
      else if (i == 2) step(~cur);
      else step(cur);
      if (valid === 1'b1) nv++;
      checks++;
      if (freq !== FW'(10) || ring !== 1'b1) begin
        failures++; $display("FAIL glitch_hold i=%0d got r=%b f=%0d exp r=1 f=10", i, ring, freq);
      end
      checks++;
      if ({valid, ring, freq} !== {m_valid, m_ring, m_freq}) begin
        failures++; $display("FAIL glitch_model i=%0d got v=%b r=%b f=%0d exp v=%b r=%b f=%0d", i, valid, ring, freq, m_valid, m_ring, m_freq);
      end
    end
    checks++;
    if (nv != 4) begin failures++; $display("FAIL glitch_valid_count got=%0d exp=4", nv); end
  endtask

  // Last accepted edge at clk 33; ring drops at clk 33+8191.
  task automatic test_timeout();
    do_reset(1'b0);
    wave(10, 4);
    for (int cc = 40; cc < 8240; cc++) begin
      step(cur);
      checks++;
      if ({valid, ring, freq} !== {1'b0, cc < 8224, FW'(10)}) begin
        failures++; $display("FAIL timeout_lit clk=%0d got v=%b r=%b f=%0d exp r=%b f=10", cc, valid, ring, freq, cc < 8224);
      end
      checks++;
      if ({valid, ring, freq} !== {m_valid, m_ring, m_freq}) begin
        failures++; $display("FAIL timeout_model clk=%0d got v=%b r=%b f=%0d exp v=%b r=%b f=%0d", cc, valid, ring, freq, m_valid, m_ring, m_freq);
      end
    end
  endtask

  task automatic test_async_reset();
    int fe;
    fe = MATCH ? 23 : 13;
    do_reset(1'b0);
    wave(10, 4);
    repeat (4) step(cur);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, ring, freq} !== {2'b00, {FW{1'b0}}}) begin
      failures++; $display("FAIL async_reset got v=%b r=%b f=%0d exp all 0", valid, ring, freq);
    end
    @(negedge clk);
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) begin
      step((i % 10 == 0) ? ~cur : cur);
      checks++;
      if ({valid, ring} !== {(i >= fe) && ((i - fe) % 10 == 0), i >= fe}) begin
        failures++; $display("FAIL rearm_lit i=%0d got v=%b r=%b first_valid=%0d", i, valid, ring, fe);
      end
      checks++;
      if ({valid, ring, freq} !== {m_valid, m_ring, m_freq}) begin
        failures++; $display("FAIL rearm_model i=%0d got v=%b r=%b f=%0d exp v=%b r=%b f=%0d", i, valid, ring, freq, m_valid, m_ring, m_freq);
      end
    end
  endtask

  // Half-period of exactly 2^FW-1: the edge coincides with saturation and wins.
  task automatic test_sat_edge();
    int nv;
    nv = 0;
    do_reset(1'b0);
    for (int i = 0; i < 3 * MAXC; i++) begin
      step((i % MAXC == 0) ? ~cur : cur);
      if (valid === 1'b1) nv++;
      checks++;
      if ({valid, ring, freq} !== {m_valid, m_ring, m_freq}) begin
        failures++; $display("FAIL sat_model i=%0d got v=%b r=%b f=%0d exp v=%b r=%b f=%0d", i, valid, ring, freq, m_valid, m_ring, m_freq);
      end
    end
    checks++;
    if (freq !== FW'(MAXC) || ring !== 1'b1) begin
      failures++; $display("FAIL sat_final got r=%b f=%0d exp r=1 f=%0d", ring, freq, MAXC);
    end
    checks++;
    if (nv != (MATCH ? 1 : 2)) begin failures++; $display("FAIL sat_valid_count got=%0d exp=%0d", nv, MATCH ? 1 : 2); end
  endtask

  task automatic test_random();
    int n, g;
    logic pv;
    n = 10; pv = 1'b0;
    do_reset(1'b0);
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 3) == 0) n = $urandom_range(MIN_H, 30);
      else if ($urandom_range(0, 1) == 1) n = (n < 30) ? n + 1 : n;
      else n = (n > MIN_H) ? n - 1 : n;
      g = ($urandom_range(0, 5) == 0) ? $urandom_range(1, n) : -1;
      for (int i = 0; i < n; i++) begin
        if (i == 0) step(~cur);
        else if (i == g || (g > 0 && i == g + 1 && i < n)) step(~cur);
        else step(cur);
        checks++;
        if ({valid, ring, freq} !== {m_valid, m_ring, m_freq}) begin
          failures++; $display("FAIL random_model seg=%0d i=%0d n=%0d got v=%b r=%b f=%0d exp v=%b r=%b f=%0d", seg, i, n, valid, ring, freq, m_valid, m_ring, m_freq);
        end
        checks++;
        if (valid === 1'b1 && pv === 1'b1) begin
          failures++; $display("FAIL random_valid_b2b seg=%0d i=%0d got=11 exp=no consecutive", seg, i);
        end
        pv = valid;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_tone();
    test_glitch();
    test_timeout();
    test_async_reset();
    test_sat_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
